// File: rtl/mux2n1_arbiter_if.sv
// Request/data/grant bundle between two requesters and the 2:1 arbiter.
// The requesters drive the master side and the arbiter drives the slave side.
interface mux2n1_arbiter_if;
    logic       req0;
    logic       req1;
    logic [3:0] in0;
    logic [3:0] in1;
    logic       grant0;
    logic       grant1;
    logic       sel;
    logic [3:0] out_data;
    logic       out_valid;

    modport master (
        output req0, req1, in0, in1,
        input  grant0, grant1, sel, out_data, out_valid
    );

    modport slave (
        input  req0, req1, in0, in1,
        output grant0, grant1, sel, out_data, out_valid
    );
endinterface

// File: rtl/mux2n1_arbiter.sv
// Two-requester round-robin arbiter that drives a shared, registered 4-bit 2:1 mux.
// The current holder is forced to hand over after HOLD_MAX cycles only while the other side waits.
module mux2n1_arbiter #(
    parameter int unsigned HOLD_MAX = 4
) (
    input logic              clk_i,
    input logic              rst_ni,
    mux2n1_arbiter_if.slave  bus
);
    localparam int unsigned     CntW     = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_MAX - 1);

    typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic [CntW-1:0] hold_q, hold_d;
    logic            sel_q, sel_d;
    logic [3:0]      out_q, out_d;
    logic            valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req0 && bus.req1) state_d = last_q ? StGnt0 : StGnt1;
                else if (bus.req0)        state_d = StGnt0;
                else if (bus.req1)        state_d = StGnt1;
            end
            StGnt0: begin
                if (!bus.req0)                      state_d = bus.req1 ? StGnt1 : StIdle;
                else if (bus.req1 && hold_q == HoldLast) state_d = StGnt1;
            end
            StGnt1: begin
                if (!bus.req1)                      state_d = bus.req0 ? StGnt0 : StIdle;
                else if (bus.req0 && hold_q == HoldLast) state_d = StGnt0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        last_d = last_q;
        sel_d  = sel_q;
        hold_d = hold_q;
        if (state_d != state_q) begin
            hold_d = '0;
            if (state_d == StGnt0) begin
                last_d = 1'b0;
                sel_d  = 1'b0;
            end else if (state_d == StGnt1) begin
                last_d = 1'b1;
                sel_d  = 1'b1;
            end
        end else if (hold_q != HoldLast) begin
            hold_d = hold_q + CntW'(1);
        end
    end

    // Data is captured only while the owner is still requesting.
    always_comb begin
        out_d   = out_q;
        valid_d = 1'b0;
        if (state_q == StGnt0 && bus.req0) begin
            out_d   = bus.in0;
            valid_d = 1'b1;
        end else if (state_q == StGnt1 && bus.req1) begin
            out_d   = bus.in1;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            hold_q  <= '0;
            sel_q   <= 1'b0;
            out_q   <= 4'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign bus.grant0    = (state_q == StGnt0);
    assign bus.grant1    = (state_q == StGnt1);
    assign bus.sel       = sel_q;
    assign bus.out_data  = out_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_mux2n1_arbiter.sv
// Directed bench for mux2n1_arbiter with HOLD_MAX=4; expected values are hand-derived.
module tb_mux2n1_arbiter;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    mux2n1_arbiter_if bus ();

    mux2n1_arbiter #(.HOLD_MAX(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic g0, input logic g1, input logic s,
                           input logic [3:0] o, input logic v);
        chk({tag, ".grant0"}, {3'b0, bus.grant0}, {3'b0, g0});
        chk({tag, ".grant1"}, {3'b0, bus.grant1}, {3'b0, g1});
        chk({tag, ".sel"}, {3'b0, bus.sel}, {3'b0, s});
        chk({tag, ".out"}, bus.out_data, o);
        chk({tag, ".valid"}, {3'b0, bus.out_valid}, {3'b0, v});
    endtask

    initial begin
        logic own_k;
        logic own_p;
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.in0  = 4'h0;
        bus.in1  = 4'h0;
        step();
        step();
        chk_all("reset", 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);

        // Tie after reset goes to requester 0 (E1), data one edge later (E2).
        rst_n    = 1'b1;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.in0  = 4'h3;
        bus.in1  = 4'hC;
        step();
        chk_all("tie_e1", 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
        step();
        chk_all("tie_e2", 1'b1, 1'b0, 1'b0, 4'h3, 1'b1);

        // Both held: owner of edge k is ((k-1)/4)%2, Out reflects owner of edge k-1.
        for (int k = 3; k <= 12; k++) begin
            step();
            own_k = 1'(((k - 1) / 4) % 2);
            own_p = 1'(((k - 2) / 4) % 2);
            chk_all($sformatf("rot_e%0d", k), !own_k, own_k, own_k,
                    own_p ? 4'hC : 4'h3, 1'b1);
        end

        // GNT0 holder drops while req1 high: switch in one edge.
        bus.req0 = 1'b0;
        bus.in1  = 4'h6;
        step();
        chk_all("drop0_e13", 1'b0, 1'b1, 1'b1, 4'h3, 1'b0);
        step();
        chk_all("drop0_e14", 1'b0, 1'b1, 1'b1, 4'h6, 1'b1);

        // Both low from GNT1: IDLE, Sel stays 1, Out holds.
        bus.req1 = 1'b0;
        step();
        chk_all("idle_e15", 1'b0, 1'b0, 1'b1, 4'h6, 1'b0);
        step();
        chk_all("idle_e16", 1'b0, 1'b0, 1'b1, 4'h6, 1'b0);

        // Lone requester 1 for 10 cycles: no forced switch.
        bus.req1 = 1'b1;
        bus.in1  = 4'hA;
        step();
        chk_all("lone_1", 1'b0, 1'b1, 1'b1, 4'h6, 1'b0);
        for (int i = 2; i <= 10; i++) begin
            step();
            chk_all($sformatf("lone_%0d", i), 1'b0, 1'b1, 1'b1, 4'hA, 1'b1);
        end

        // Async reset mid-GNT1 with Out=5.
        bus.in1 = 4'h5;
        step();
        chk("pre_rst.out", bus.out_data, 4'h5);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        #1;
        rst_n = 1'b1;
        step();
        chk_all("post_rst_tie", 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mux2n1_arbiter.md
MUX2N1_ARBITER -- requirements
Module: mux2n1_arbiter

Interface
REQ-001 Parameter: HOLD_MAX, default 4, the maximum consecutive cycles one requester keeps the grant while the other requester is waiting.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Clock  input  1  rising-edge clock for all state.
REQ-004 Reset  input  1  asynchronous active-low reset; 0 forces reset state immediately.
REQ-005 Req0  input  1  requester 0 wants the shared 4-bit path.
REQ-006 Req1  input  1  requester 1 wants the shared 4-bit path.
REQ-007 Input0  input  4  requester 0 data.
REQ-008 Input1  input  4  requester 1 data.
REQ-009 Grant0  output  1  requester 0 owns the path this cycle.
REQ-010 Grant1  output  1  requester 1 owns the path this cycle.
REQ-011 Sel  output  1  select for the shared 2:1 mux; 1 selects Input1.
REQ-012 Out  output  4  registered data of the granted requester.
REQ-013 OutValid  output  1  Out holds data captured under a grant.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, GNT0 and GNT1.
REQ-015 Grant0 SHALL equal (state==GNT0), and Grant1 SHALL equal (state==GNT1); both are registered, and they are never high together.
REQ-016 Sel SHALL be 1 in GNT1 and 0 in GNT0; in IDLE, Sel SHALL hold its last value.
REQ-017 A priority pointer Last SHALL record the most recently granted requester, and it SHALL update on every entry into GNT0 or GNT1.
REQ-018 From IDLE: only Req0 -> GNT0; only Req1 -> GNT1; both -> the requester not equal to Last; neither -> IDLE.
REQ-019 From GNTx with ReqX=0: the other request high -> the other grant; otherwise -> IDLE.
REQ-020 From GNTx with ReqX=1 and the other request high, when HoldCnt==HOLD_MAX-1, the FSM SHALL move to the other grant (forced rotation).
REQ-021 From GNTx with ReqX=1 in all other cases, the FSM SHALL stay in GNTx.
REQ-022 HoldCnt SHALL be clog2(HOLD_MAX) bits wide.
REQ-023 HoldCnt SHALL clear on any state change, increment each cycle the state is unchanged, and saturate at HOLD_MAX-1.
REQ-024 When the other request is low, HoldCnt SHALL NOT force a switch, so a lone requester keeps the grant indefinitely.
REQ-025 Grant latency: a request seen at edge n in IDLE SHALL produce the grant after edge n, with one cycle of latency.
REQ-026 Each cycle in GNTx with ReqX=1, Out SHALL be loaded with InputX and OutValid set to 1 at the next edge.
REQ-027 In every other cycle, OutValid SHALL be set to 0 at the next edge, and Out SHALL hold its value.
REQ-028 Data latency: Out and OutValid SHALL reflect InputX one cycle after it is sampled under the grant.
REQ-029 A switch GNT0->GNT1 or GNT1->GNT0 SHALL take exactly one edge, with no IDLE bubble.
REQ-030 During a switch, the OutValid stream SHALL stay continuous if the new owner's request is high.
REQ-031 When a grant holder drops its request and re-raises it in the same cycle the other requester raises its request, arbitration SHALL go by REQ-018 through IDLE.

Reset
REQ-032 While Reset=0, the outputs SHALL be: state=IDLE, Grant0=0, Grant1=0, Sel=0, Out=4'h0, OutValid=0.
REQ-033 While Reset=0, the internal state SHALL be: Last=1 (so requester 0 wins the first tie), HoldCnt=0.
REQ-034 Reset asserted mid-grant SHALL drop both grants and OutValid asynchronously, without waiting for a clock edge.
REQ-035 After Reset deasserts, the first arbitration SHALL follow REQ-018 with Last=1.

Verification
REQ-036 Reset, then Req0=1 and Req1=1 raised in the same cycle -> Grant0=1 one edge later, then Out=Input0 with OutValid=1 one edge after that.
REQ-037 With HOLD_MAX=4 and both requests held high continuously -> the grant alternates every 4 cycles (Grant0 x4, Grant1 x4, ...), Sel toggles with it, and there is no IDLE cycle.
REQ-038 Req1 only, held for 10 cycles with Input1=4'hA -> Grant1 for all 10 cycles, Out=4'hA, OutValid=1 from the second granted edge, and no forced switch.
REQ-039 GNT0 holder drops Req0 while Req1=1 -> GNT1 on the next edge, Sel=1, then Out=Input1.
REQ-040 Reset pulled low mid-GNT1 with Out=4'h5 -> Grant1=0, OutValid=0 and Out=4'h0 immediately, then a tie after release goes to requester 0.
REQ-041 Both requests low from GNT1 -> IDLE with Sel still 1, OutValid=0 one edge later, and Out holding its last value.
